bundle_ctrl: RTL
================

# bundle_ctrl

Sequencer for a bank of majority-bundling counters in the HPU datapath. It clears the counter bank, and gates per-core store strobes for a programmed number of bundling rounds. After the counter pipeline drains, it captures the bank's sign bits as one bundled hypervector word and hands that word downstream over a valid/ready handshake. It sits between the core array, which supplies `core_result` directly to the counters, and the writeback path.

## Interface
- `CORENUM`, 32, number of cores; width of store mask.
- `DIM`, 32, number of counter lanes in the bank; width of the result word.
- `ITER_W`, 16, width of the round count.
- `PIPE_LAT`, 3, cycles from a store strobe until the counter `sign_bit` reflects it. Must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle job start request.
- `num_items`  in  ITER_W  number of rounds to bundle; sampled on an accepted start.
- `core_en`  in  CORENUM  active-core mask; sampled on an accepted start.
- `in_valid`  in  1  the cores present one round of results this cycle.
- `in_ready`  out  1  the controller accepts a round.
- `ctr_clr`  out  1  synchronous active-high clear to every counter in the bank.
- `ctr_store`  out  CORENUM  per-core store strobe to every lane of the bank.
- `ctr_sign`  in  DIM  sign bits from the bank; lane i drives bit i.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  DIM  captured sign bits.
- `busy`  out  1  the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, OUT.
- **IDLE**
  - `busy`=0, `in_ready`=0.
  - `start` with `num_items`≠0: latch `num_items` and `core_en`, then go to CLEAR.
  - `start` with `num_items`=0: pulse `done` next cycle, stay in IDLE, produce no output.
- **CLEAR**
  - `ctr_clr`=1 for exactly one cycle, then go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `ctr_store` = latched mask, combinationally in the same cycle, and the remaining count is decremented.
  - At every other time, `ctr_store`=0.
  - After the final accepted round, go to DRAIN with the drain counter loaded to `PIPE_LAT`-1.
- **DRAIN**
  - Stay for exactly `PIPE_LAT` cycles.
  - On the clock edge ending the last DRAIN cycle, register `out_data` ← `ctr_sign`, then go to OUT.
- **OUT**
  - `out_valid`=1; `out_data` is held stable until `out_valid`&&`out_ready`.
  - On acceptance: `done` pulses in the next cycle, and the FSM returns to IDLE.
- `start` in any state other than IDLE is ignored; it is neither queued nor allowed to alter the latched parameters.
- Sign-bit semantics: bit=1 means the lane sum is negative. A tie (sum 0) reads 0. No inversion is applied.
- Remaining count is unsigned, ITER_W bits. Reaching 0 is the only exit from ACCUM; there is no wrap-around.

## Timing
- Reset values, applied asynchronously: state=IDLE, `in_ready`=0, `ctr_clr`=0, `ctr_store`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- Reset asserted mid-job aborts the job immediately. The next job's CLEAR restores the counter bank.
- Cycle sequence, start accepted in cycle S:
  - CLEAR is cycle S+1.
  - The earliest round is accepted in cycle S+2.
- Cycle sequence, last round accepted in cycle T:
  - DRAIN occupies cycles T+1..T+PIPE_LAT.
  - `out_valid` first rises in cycle T+PIPE_LAT+1.
- Minimum job latency, from start to `out_valid`, with `in_valid` held high: 1 + N + `PIPE_LAT` + 1 cycles.
- `in_valid` gaps in ACCUM simply stall the job; the drain timer does not run during ACCUM.
- `busy` is registered and equals (state≠IDLE).
- `done` is registered, high for exactly one cycle.

## Structure
- Shared package `bundle_pkg`:
  - state enum `bundle_state_t`.
  - default constant `BUNDLE_PIPE_LAT`=3.
- No sub-module. The FSM, the round down-counter and the drain down-counter are inline.
- The counter bank is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-ACCUM, then release: all outputs are 0 and state is IDLE. A fresh start with N=2 completes normally.
- CORENUM=4, DIM=4, `core_en`=4'b1111, N=3, `in_valid` held high, bank model returns `ctr_sign`=4'b0101:
  - `ctr_clr` is high in cycle S+1.
  - `ctr_store`=4'b1111 in cycles S+2..S+4.
  - `out_valid` rises in cycle S+8 with `out_data`=4'b0101.
- N=0 start: `done` pulses in cycle S+1. `ctr_clr`, `ctr_store` and `out_valid` never assert.
- `core_en`=4'b0110, N=2, `in_valid` toggling 1,0,0,1: `ctr_store`=4'b0110 only in cycles S+2 and S+5. DRAIN starts in cycle S+6.
- `out_ready` held low for 5 cycles in OUT: `out_valid` and `out_data` stay stable, a `start` pulse is ignored, and `done` pulses one cycle after the handshake.
- Back-to-back jobs, with the second start in the cycle after `done`: the second CLEAR clears the bank, and the first result does not leak into the second result.

Source files
------------

// File: rtl/bundle_pkg.sv
// Shared types and defaults for the majority-bundling sequencer.
package bundle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      DRAIN,
      OUT
   } bundle_state_t;

   localparam int BUNDLE_PIPE_LAT = 3;

endpackage : bundle_pkg

// File: rtl/bundle_ctrl.sv
// Sequencer for a bank of bundling counters: clear, gated store rounds,
// pipeline drain, then hand the captured sign word downstream.
module bundle_ctrl
   import bundle_pkg::*;
#(
   parameter int CORENUM  = 32,
   parameter int DIM      = 32,
   parameter int ITER_W   = 16,
   parameter int PIPE_LAT = BUNDLE_PIPE_LAT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ITER_W-1:0]  num_items,
   input  logic [CORENUM-1:0] core_en,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               ctr_clr,
   output logic [CORENUM-1:0] ctr_store,
   input  logic [DIM-1:0]     ctr_sign,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIM-1:0]     out_data,
   output logic               busy,
   output logic               done
);

   localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

   bundle_state_t      state, state_nxt;
   logic [ITER_W-1:0]  remaining, remaining_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
   logic [CORENUM-1:0] mask, mask_nxt;
   logic [DIM-1:0]     data_nxt;
   logic               done_nxt;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_nxt     = state;
      remaining_nxt = remaining;
      drain_cnt_nxt = drain_cnt;
      mask_nxt      = mask;
      data_nxt      = out_data;
      done_nxt      = 1'b0;
      in_ready      = 1'b0;
      ctr_clr       = 1'b0;
      ctr_store     = '0;
      out_valid     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (num_items != '0) begin
                  remaining_nxt = num_items;
                  mask_nxt      = core_en;
                  state_nxt     = CLEAR;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         CLEAR: begin
            ctr_clr   = 1'b1;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ctr_store     = mask;
               remaining_nxt = remaining - ITER_W'(1);
               // Count never reaches 0 while in ACCUM, so 1 marks the final round.
               if (remaining == ITER_W'(1)) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt == '0) begin
               data_nxt  = ctr_sign;
               state_nxt = OUT;
            end else begin
               drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= '0;
         drain_cnt <= '0;
         mask      <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         drain_cnt <= drain_cnt_nxt;
         mask      <= mask_nxt;
         out_data  <= data_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
      end
   end

endmodule : bundle_ctrl
